// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
//  word_t      : 32-bit RAM word
//  ramstate_t  : RAM model handshake state (FREE/BUSY/ACCESS/ERROR)
//  arb_state_t : arbiter FSM state, exported so benches can name it
//  ram_req_t   : one RAM request beat (enables, address, write data)
package imem_dmem_arbiter_pkg;

    localparam int unsigned WORD_W                = 32;
    localparam int unsigned STARVE_MAX_DEFAULT    = 4;
    localparam int unsigned ERR_RETRY_MAX_DEFAULT = 3;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DACC   = 2'd1,
        IACC   = 2'd2,
        ERRGAP = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic  ren;
        logic  wen;
        word_t addr;
        word_t store;
    } ram_req_t;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between pipeline datapath, arbiter and RAM.
//  Fetch port : iREN, iaddr -> ; <- iwait, iload
//  Data port  : dREN, dWEN, daddr, dstore -> ; <- dwait, dload
//  RAM port   : ramREN, ramWEN, ramaddr, ramstore -> ; <- ramload, ramstate
//  slave  : arbiter view (answers fetch/data requests, drives the RAM)
//  master : environment view (datapath + RAM model)
interface imem_dmem_arbiter_if;
    import imem_dmem_arbiter_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates the single-ported RAM between the fetch port and the data port.
// One RAM transaction at a time; data has priority unless fetch has been
// passed over STARVE_MAX times in a row. RAM ERROR responses are retried after
// a one-cycle gap; after ERR_RETRY_MAX errors the access is released with zero
// data and mem_err is set (sticky until reset).
//  CLK, nRST : clock, asynchronous active-low reset
//  bus       : fetch, data and RAM signals (slave modport)
//  mem_err   : registered sticky error flag
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX    = STARVE_MAX_DEFAULT,
    parameter int unsigned ERR_RETRY_MAX = ERR_RETRY_MAX_DEFAULT
) (
    input  logic               CLK,
    input  logic               nRST,
    imem_dmem_arbiter_if.slave bus,
    output logic               mem_err
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int unsigned RETRY_W  = $clog2(ERR_RETRY_MAX + 1);

    arb_state_t          state_q, state_d;
    logic                gap_data_q, gap_data_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [RETRY_W-1:0]  retry_q, retry_d, retry_inc;
    logic                mem_err_d;

    logic     dreq;
    logic     force_i;
    logic     pick_d;
    logic     grant_d, grant_i;
    logic     act_d, act_i;
    logic     done_d, done_i;
    logic     err_last;
    ram_req_t ram_req;

    assign dreq    = bus.dREN | bus.dWEN;
    assign force_i = bus.iREN && (starve_q == STARVE_W'(STARVE_MAX));
    assign pick_d  = dreq && !force_i;

    // Grant is combinational in IDLE so the RAM sees the request in the same
    // cycle; it is held in DACC/IACC and absent in ERRGAP and during reset.
    assign grant_d = nRST && ((state_q == IDLE && pick_d) || state_q == DACC);
    assign grant_i = nRST && ((state_q == IDLE && !pick_d && bus.iREN) || state_q == IACC);

    // A grant whose request has dropped is a flush: nothing is driven.
    assign act_d = grant_d && dreq;
    assign act_i = grant_i && bus.iREN;

    // RAM request mux; a simultaneous dREN/dWEN is treated as a write.
    always_comb begin
        ram_req = '0;
        if (act_d) begin
            ram_req.ren   = bus.dREN && !bus.dWEN;
            ram_req.wen   = bus.dWEN;
            ram_req.addr  = bus.daddr;
            ram_req.store = bus.dstore;
        end else if (act_i) begin
            ram_req.ren  = 1'b1;
            ram_req.addr = bus.iaddr;
        end
    end

    assign bus.ramREN   = ram_req.ren;
    assign bus.ramWEN   = ram_req.wen;
    assign bus.ramaddr  = ram_req.addr;
    assign bus.ramstore = ram_req.store;

    // Next-state, retry/starvation bookkeeping and completion strobes.
    always_comb begin
        state_d    = state_q;
        gap_data_d = gap_data_q;
        starve_d   = starve_q;
        retry_d    = retry_q;
        mem_err_d  = mem_err;
        done_d     = 1'b0;
        done_i     = 1'b0;
        err_last   = 1'b0;
        retry_inc  = retry_q + RETRY_W'(1);

        if (state_q == ERRGAP) begin
            state_d = gap_data_q ? DACC : IACC;
        end else if (grant_d || grant_i) begin
            if (!(act_d || act_i)) begin
                state_d = IDLE;
                retry_d = '0;
            end else if (bus.ramstate == ACCESS) begin
                done_d  = act_d;
                done_i  = act_i;
                state_d = IDLE;
                retry_d = '0;
            end else if (bus.ramstate == ERROR) begin
                if (retry_inc == RETRY_W'(ERR_RETRY_MAX)) begin
                    // Out of retries: release the port with zero data.
                    done_d    = act_d;
                    done_i    = act_i;
                    err_last  = 1'b1;
                    mem_err_d = 1'b1;
                    state_d   = IDLE;
                    retry_d   = '0;
                end else begin
                    retry_d    = retry_inc;
                    gap_data_d = act_d;
                    state_d    = ERRGAP;
                end
            end else begin
                state_d = act_d ? DACC : IACC;
            end
        end

        // Count data completions that overtook a waiting fetch.
        if (!bus.iREN || done_i) begin
            starve_d = '0;
        end else if (done_d && starve_q != STARVE_W'(STARVE_MAX)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    assign bus.iwait = bus.iREN && !done_i;
    assign bus.dwait = dreq && !done_d;
    assign bus.iload = (done_i && !err_last) ? bus.ramload : '0;
    assign bus.dload = (done_d && !err_last) ? bus.ramload : '0;

    // State registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            gap_data_q <= 1'b0;
            starve_q   <= '0;
            retry_q    <= '0;
            mem_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_data_q <= gap_data_d;
            starve_q   <= starve_d;
            retry_q    <= retry_d;
            mem_err    <= mem_err_d;
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: a driver replays per-port request
// queues, a RAM model answers with programmable latency and error count, and
// a monitor checks every released access against the expected-completion queue.
module tb_imem_dmem_arbiter;
    import imem_dmem_arbiter_pkg::*;

    typedef struct {
        logic  we;
        word_t addr;
        word_t store;
        int    abort_after;
    } item_t;

    typedef struct {
        bit    is_d;
        bit    we;
        word_t addr;
        word_t data;
        int    off;
    } exp_t;

    logic CLK;
    logic nRST;
    logic mem_err;

    imem_dmem_arbiter_if bus ();

    imem_dmem_arbiter #(.STARVE_MAX(4), .ERR_RETRY_MAX(3)) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .bus    (bus),
        .mem_err(mem_err)
    );

    int    vecs;
    int    miss;
    int    cyc;
    int    t0;
    exp_t  sb[$];
    item_t i_items[$];
    item_t d_items[$];
    bit    i_active;
    bit    d_active;

    // RAM model controls
    int lat;
    int err_req;
    bit err_clr;
    int busy_cnt;
    int err_used;
    bit [31:0] mem [1024];
    bit        wr_valid [1024];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // RAM model: BUSY for lat cycles, then ERROR while errors remain, else ACCESS.
    always_comb begin
        if (!(bus.ramREN || bus.ramWEN))      bus.ramstate = FREE;
        else if (busy_cnt < lat)              bus.ramstate = BUSY;
        else if (err_used < err_req)          bus.ramstate = ERROR;
        else                                  bus.ramstate = ACCESS;
    end

    assign bus.ramload = wr_valid[bus.ramaddr[11:2]] ? mem[bus.ramaddr[11:2]]
                                                     : (32'hC0DE_0000 | {16'h0, bus.ramaddr[15:0]});

    always @(posedge CLK) begin
        if (err_clr) err_used <= 0;
        if (bus.ramREN || bus.ramWEN) begin
            if (bus.ramstate == ACCESS) begin
                busy_cnt <= 0;
                if (bus.ramWEN) begin
                    mem[bus.ramaddr[11:2]]      <= bus.ramstore;
                    wr_valid[bus.ramaddr[11:2]] <= 1'b1;
                end
            end else if (bus.ramstate == ERROR) begin
                busy_cnt <= 0;
                err_used <= err_used + 1;
            end else begin
                busy_cnt <= busy_cnt + 1;
            end
        end else begin
            busy_cnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s @cyc %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Request driver: presents queued items, advances on completion or abort.
    initial begin : driver
        item_t i_cur, d_cur;
        int    i_cyc, d_cyc;
        bit    i_done_s, d_done_s;
        i_cyc = 0; d_cyc = 0;
        i_cur = '{1'b0, '0, '0, 0};
        d_cur = '{1'b0, '0, '0, 0};
        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
        forever begin
            @(negedge CLK);
            i_done_s = nRST && bus.iREN && !bus.iwait;
            d_done_s = nRST && (bus.dREN || bus.dWEN) && !bus.dwait;
            @(posedge CLK);
            #1;
            if (!nRST) begin
                i_active = 1'b0;
                d_active = 1'b0;
            end else begin
                if (i_active) begin
                    i_cyc++;
                    if (i_done_s || (i_cur.abort_after != 0 && i_cyc >= i_cur.abort_after)) i_active = 1'b0;
                end
                if (!i_active && i_items.size() != 0) begin
                    i_cur = i_items.pop_front(); i_active = 1'b1; i_cyc = 0;
                end
                if (d_active) begin
                    d_cyc++;
                    if (d_done_s || (d_cur.abort_after != 0 && d_cyc >= d_cur.abort_after)) d_active = 1'b0;
                end
                if (!d_active && d_items.size() != 0) begin
                    d_cur = d_items.pop_front(); d_active = 1'b1; d_cyc = 0;
                end
            end
            bus.iREN   = i_active;
            bus.iaddr  = i_active ? i_cur.addr : '0;
            bus.dREN   = d_active && !d_cur.we;
            bus.dWEN   = d_active && d_cur.we;
            bus.daddr  = d_active ? d_cur.addr : '0;
            bus.dstore = d_active ? d_cur.store : '0;
        end
    end

    task automatic sb_check(input bit is_d);
        exp_t e;
        if (sb.size() == 0) begin
            vecs++;
            miss++;
            $display("FAIL unexpected_completion @cyc %0d: port %0d released, expected no completion", cyc, is_d);
            return;
        end
        e = sb.pop_front();
        chk("port", 32'(is_d), 32'(e.is_d));
        chk("latency_offset", 32'(cyc - t0), 32'(e.off));
        chk("ramaddr", bus.ramaddr, e.addr);
        if (e.we) chk("ramstore", bus.ramstore, e.data);
        else      chk(is_d ? "dload" : "iload", is_d ? bus.dload : bus.iload, e.data);
    endtask

    // Monitor: every released wait must match the next expected completion.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (bus.iREN && !bus.iwait) sb_check(1'b0);
            if ((bus.dREN || bus.dWEN) && !bus.dwait) sb_check(1'b1);
        end
    end

    task automatic start_batch();
        @(negedge CLK);
        t0 = cyc + 1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(sb.size() == 0 && !i_active && !d_active && i_items.size() == 0 && d_items.size() == 0)
               && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_timeout", 32'(n < 200), 32'd1);
        sb.delete();
        i_items.delete();
        d_items.delete();
        @(negedge CLK);
    endtask

    initial begin
        nRST = 1'b0; lat = 0; err_req = 0; err_clr = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
        chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
        chk("rst_ramaddr", bus.ramaddr, 32'd0);
        chk("rst_ramstore", bus.ramstore, 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_iload", bus.iload, 32'd0);
        chk("rst_dload", bus.dload, 32'd0);
        @(posedge CLK); #2 nRST = 1'b1;

        // fetch only, two BUSY cycles before ACCESS
        lat = 2;
        start_batch();
        i_items.push_back('{1'b0, 32'h40, 32'h0, 0});
        sb.push_back('{1'b0, 1'b0, 32'h40, 32'hC0DE_0040, 2});
        drain();

        // simultaneous write and fetch: write first, fetch next cycle
        lat = 0;
        start_batch();
        d_items.push_back('{1'b1, 32'h100, 32'hDEAD_BEEF, 0});
        i_items.push_back('{1'b0, 32'h44, 32'h0, 0});
        sb.push_back('{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 0});
        sb.push_back('{1'b0, 1'b0, 32'h44, 32'hC0DE_0044, 1});
        drain();
        start_batch();
        d_items.push_back('{1'b0, 32'h100, 32'h0, 0});
        sb.push_back('{1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 0});
        drain();

        // starvation: four data grants, forced fetch, then data again
        start_batch();
        i_items.push_back('{1'b0, 32'h48, 32'h0, 0});
        for (int k = 0; k < 6; k++) d_items.push_back('{1'b0, 32'h400 + 32'(4 * k), 32'h0, 0});
        sb.push_back('{1'b1, 1'b0, 32'h400, 32'hC0DE_0400, 0});
        sb.push_back('{1'b1, 1'b0, 32'h404, 32'hC0DE_0404, 1});
        sb.push_back('{1'b1, 1'b0, 32'h408, 32'hC0DE_0408, 2});
        sb.push_back('{1'b1, 1'b0, 32'h40C, 32'hC0DE_040C, 3});
        sb.push_back('{1'b0, 1'b0, 32'h48,  32'hC0DE_0048, 4});
        sb.push_back('{1'b1, 1'b0, 32'h410, 32'hC0DE_0410, 5});
        sb.push_back('{1'b1, 1'b0, 32'h414, 32'hC0DE_0414, 6});
        drain();

        // two errors then ACCESS: two gap cycles, valid data, no mem_err
        @(negedge CLK); err_clr = 1'b1; err_req = 2;
        @(negedge CLK); err_clr = 1'b0;
        start_batch();
        d_items.push_back('{1'b0, 32'h200, 32'h0, 0});
        sb.push_back('{1'b1, 1'b0, 32'h200, 32'hC0DE_0200, 4});
        drain();
        chk("mem_err_after_2_errors", 32'(mem_err), 32'd0);

        // three errors: released with zero data, mem_err set
        @(negedge CLK); err_clr = 1'b1; err_req = 3;
        @(negedge CLK); err_clr = 1'b0;
        start_batch();
        d_items.push_back('{1'b0, 32'h204, 32'h0, 0});
        sb.push_back('{1'b1, 1'b0, 32'h204, 32'h0, 4});
        drain();
        chk("mem_err_after_3_errors", 32'(mem_err), 32'd1);

        // fetch flushed during IACC, pending data read granted afterwards
        lat = 3;
        start_batch();
        i_items.push_back('{1'b0, 32'h80, 32'h0, 2});
        sb.push_back('{1'b1, 1'b0, 32'h300, 32'hC0DE_0300, 6});
        @(negedge CLK);
        d_items.push_back('{1'b0, 32'h300, 32'h0, 0});
        @(negedge CLK);
        chk("flush_iwait_held", 32'(bus.iwait), 32'd1);
        chk("flush_ramaddr_fetch", bus.ramaddr, 32'h80);
        chk("flush_dwait_pending", 32'(bus.dwait), 32'd1);
        @(negedge CLK);
        chk("flush_ramREN_low", 32'(bus.ramREN), 32'd0);
        chk("flush_dwait_still", 32'(bus.dwait), 32'd1);
        @(negedge CLK);
        chk("flush_ramREN_data", 32'(bus.ramREN), 32'd1);
        chk("flush_ramaddr_data", bus.ramaddr, 32'h300);
        drain();

        // reset in the middle of a data access
        start_batch();
        d_items.push_back('{1'b0, 32'h50C, 32'h0, 0});
        @(negedge CLK);
        chk("pre_reset_ramREN", 32'(bus.ramREN), 32'd1);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("midrst_ramREN", 32'(bus.ramREN), 32'd0);
        chk("midrst_ramWEN", 32'(bus.ramWEN), 32'd0);
        chk("midrst_mem_err", 32'(mem_err), 32'd0);
        chk("midrst_dwait", 32'(bus.dwait), 32'd1);
        @(negedge CLK);
        @(posedge CLK); #2 nRST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("postrst_ramREN", 32'(bus.ramREN), 32'd0);
        chk("postrst_sb_empty", 32'(sb.size()), 32'd0);
        lat = 0;
        start_batch();
        i_items.push_back('{1'b0, 32'h44, 32'h0, 0});
        sb.push_back('{1'b0, 1'b0, 32'h44, 32'hC0DE_0044, 0});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
